// File: rtl/sprite_line_sorter.sv
// Per-line sprite visibility scan: cull table entries against one column and
// collect up to MAX_VIS survivors. Define SPRITE_SORT_EN for painter's-order sorting.
module sprite_line_sorter #(
    parameter int unsigned NUM_SPRITES = 128,
    parameter int unsigned MAX_VIS     = 8,
    parameter int unsigned META_W      = 120
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(NUM_SPRITES):0]     active_count,
    input  logic [8:0]                       x,
    input  logic [15:0]                      wall_z,
    output logic [$clog2(NUM_SPRITES)-1:0]   stmeta_raddr,
    input  logic [META_W-1:0]                stmeta_read_data,
    output logic                             busy,
    output logic                             done,
    output logic                             overflow,
    output logic [$clog2(MAX_VIS+1)-1:0]     sprite_count,
    input  logic [$clog2(MAX_VIS)-1:0]       rd_addr,
    output logic [META_W-1:0]                rd_meta
);

    localparam int unsigned AW  = $clog2(NUM_SPRITES);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SCW = $clog2(MAX_VIS + 1);
    localparam int unsigned RAW = $clog2(MAX_VIS);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [8:0]          x_q, x_d;
    logic [15:0]         wall_q, wall_d;
    logic [SCW-1:0]      count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                tv_q, tv_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [META_W-1:0]   rd_meta_q, rd_meta_d;
    logic [META_W-1:0]   list_q [MAX_VIS];
    logic [META_W-1:0]   list_d [MAX_VIS];

    logic [15:0]         z_new;
    logic signed [15:0]  xs_new, xe_new, x_ext;
    logic                vis;
    logic                full;

    // Visibility of the entry whose read data arrives this cycle
    always_comb begin
        z_new  = stmeta_read_data[111:96];
        xs_new = $signed(stmeta_read_data[31:16]);
        xe_new = $signed(stmeta_read_data[15:0]);
        x_ext  = $signed({7'b0, x_q});
        vis    = tv_q && ($signed(z_new) > 16'sd0) && (z_new < wall_q)
                 && (xs_new <= x_ext) && (xe_new >= x_ext);
        full   = (count_q == SCW'(MAX_VIS));
    end

`ifdef SPRITE_SORT_EN
    logic [MAX_VIS-1:0]  ge, ge_prev, ge_next;
    logic [META_W-1:0]   up_meta [MAX_VIS];
    logic [META_W-1:0]   dn_meta [MAX_VIS];

    // ge marks the prefix of entries at least as far as the new one (keeps ties stable)
    always_comb begin
        for (int i = 0; i < MAX_VIS; i++) begin
            ge[i] = (SCW'(i) < count_q) && (list_q[i][111:96] >= z_new);
        end
        ge_prev[0] = 1'b1;
        up_meta[0] = stmeta_read_data;
        for (int i = 1; i < MAX_VIS; i++) begin
            ge_prev[i] = ge[i-1];
            up_meta[i] = list_q[i-1];
        end
        ge_next[MAX_VIS-1] = 1'b0;
        dn_meta[MAX_VIS-1] = stmeta_read_data;
        for (int i = 0; i < MAX_VIS - 1; i++) begin
            ge_next[i] = ge[i+1];
            dn_meta[i] = list_q[i+1];
        end
    end
`endif

    // Next-state, list update and output computation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        wall_d  = wall_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        list_d  = list_q;
        tv_d    = (state_q == SCAN);

        if (vis) begin
`ifdef SPRITE_SORT_EN
            if (!full) begin
                for (int i = 0; i < MAX_VIS; i++) begin
                    if (!ge[i]) begin
                        list_d[i] = ge_prev[i] ? stmeta_read_data : up_meta[i];
                    end
                end
                count_d = count_q + SCW'(1);
            end else begin
                ovf_d = 1'b1;
                // Nearer than the farthest entry: drop entry 0 and slot the new one in
                if (z_new < list_q[0][111:96]) begin
                    for (int i = 0; i < MAX_VIS; i++) begin
                        list_d[i] = ge_next[i] ? dn_meta[i]
                                  : (ge[i] ? stmeta_read_data : list_q[i]);
                    end
                end
            end
`else
            if (!full) begin
                for (int i = 0; i < MAX_VIS; i++) begin
                    if (SCW'(i) == count_q) begin
                        list_d[i] = stmeta_read_data;
                    end
                end
                count_d = count_q + SCW'(1);
            end else begin
                ovf_d = 1'b1;
            end
`endif
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    wall_d  = wall_z;
                    cnt_d   = active_count;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    addr_d  = '0;
                    state_d = (active_count == '0) ? DRAIN : SCAN;
                end
            end
            SCAN: begin
                if ({1'b0, addr_q} == CW'(cnt_q - CW'(1))) begin
                    addr_d  = '0;
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);

        rd_meta_d = '0;
        for (int i = 0; i < MAX_VIS; i++) begin
            if (RAW'(i) == rd_addr) begin
                rd_meta_d = list_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            wall_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            tv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            wall_q  <= wall_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            tv_q    <= tv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // List storage and read port carry no reset; contents are meaningless until a scan ends
    always_ff @(posedge clk) begin
        list_q    <= list_d;
        rd_meta_q <= rd_meta_d;
    end

    assign stmeta_raddr = addr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow     = ovf_q;
    assign sprite_count = count_q;
    assign rd_meta      = rd_meta_q;

endmodule

// File: tb/tb_sprite_line_sorter.sv
// Scoreboard bench for sprite_line_sorter; expectations follow SPRITE_SORT_EN when defined.
module tb_sprite_line_sorter;

    localparam int unsigned NS = 128;
    localparam int unsigned MV = 8;
    localparam int unsigned MW = 120;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     active_count = '0;
    logic [8:0]     x = '0;
    logic [15:0]    wall_z = '0;
    logic [6:0]     stmeta_raddr;
    logic [MW-1:0]  stmeta_read_data = '0;
    logic           busy, done, overflow;
    logic [3:0]     sprite_count;
    logic [2:0]     rd_addr = '0;
    logic [MW-1:0]  rd_meta;

    logic           rd_req = 1'b0;
    logic           rd_pend = 1'b0;
    logic [MW-1:0]  mem [NS];
    int             cyc = 0;
    int             n_tests = 0;
    int             n_fail = 0;

    typedef struct {string name; int cyc; int cnt; int ovf;} done_exp_t;
    typedef struct {string name; logic [MW-1:0] meta;} rd_exp_t;
    done_exp_t dq[$];
    rd_exp_t   rq[$];

    sprite_line_sorter dut (
        .clk(clk), .rst(rst), .start(start), .active_count(active_count),
        .x(x), .wall_z(wall_z), .stmeta_raddr(stmeta_raddr),
        .stmeta_read_data(stmeta_read_data), .busy(busy), .done(done),
        .overflow(overflow), .sprite_count(sprite_count), .rd_addr(rd_addr),
        .rd_meta(rd_meta)
    );

    always #5 clk = ~clk;

    // One-cycle-latency table model and cycle counter
    always @(posedge clk) begin
        stmeta_read_data <= mem[stmeta_raddr];
        cyc     <= cyc + 1;
        rd_pend <= rd_req;
    end

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input int idx, input logic [15:0] z,
                                         input logic [15:0] xs, input logic [15:0] xe);
        logic [MW-1:0] m;
        m = '0;
        m[111:96] = z;
        m[47:32]  = 16'(idx);
        m[31:16]  = xs;
        m[15:0]   = xe;
        return m;
    endfunction

    // Monitor: pop expectations whenever the DUT presents a result
    always @(negedge clk) begin
        done_exp_t d;
        rd_exp_t   r;
        if (rd_pend) begin
            check("rd_expected", MW'(rq.size() != 0), MW'(1));
            if (rq.size() != 0) begin
                r = rq.pop_front();
                check(r.name, rd_meta, r.meta);
            end
        end
        if (done) begin
            check("done_expected", MW'(dq.size() != 0), MW'(1));
            if (dq.size() != 0) begin
                d = dq.pop_front();
                check({d.name, "_done_cycle"}, MW'(cyc), MW'(d.cyc));
                check({d.name, "_count"}, MW'(sprite_count), MW'(d.cnt));
                check({d.name, "_overflow"}, MW'(overflow), MW'(d.ovf));
                check({d.name, "_raddr_idle"}, MW'(stmeta_raddr), MW'(0));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < NS; i++) mem[i] = mk(i, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic scan(input string name, input int n, input logic [8:0] xx,
                        input logic [15:0] wz, input int ecnt, input int eovf, input bit hold);
        done_exp_t d;
        @(negedge clk);
        x = xx;
        wall_z = wz;
        active_count = 8'(n);
        start = 1'b1;
        d.name = name;
        d.cyc  = cyc + n + 2;
        d.cnt  = ecnt;
        d.ovf  = eovf;
        dq.push_back(d);
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int k = 0; k < n + 20 && dq.size() != 0; k++) @(negedge clk);
        start = 1'b0;
        check({name, "_timeout"}, MW'(dq.size()), MW'(0));
    endtask

    task automatic rd(input string name, input int idx, input logic [MW-1:0] e);
        rd_exp_t r;
        @(negedge clk);
        r.name = name;
        r.meta = e;
        rq.push_back(r);
        rd_addr = 3'(idx);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    initial begin
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", MW'(busy), MW'(0));
        check("reset_done", MW'(done), MW'(0));
        check("reset_overflow", MW'(overflow), MW'(0));
        check("reset_count", MW'(sprite_count), MW'(0));

        // Depth and column cull
        clear_mem();
        mem[0] = mk(0, 16'd600, 16'd50, 16'd150);
        mem[1] = mk(1, 16'd0, 16'd50, 16'd150);
        mem[2] = mk(2, 16'hFFFD, 16'd50, 16'd150);
        mem[3] = mk(3, 16'd200, 16'd50, 16'd150);
        scan("cull", 4, 9'd100, 16'd500, 1, 0, 1'b0);
        rd("cull_e0", 0, mem[3]);

        // Boundary compares: inclusive x range, strict wall depth, signed starts
        clear_mem();
        mem[0] = mk(0, 16'd499, 16'd100, 16'd100);
        mem[1] = mk(1, 16'd10, 16'd101, 16'd200);
        mem[2] = mk(2, 16'd10, 16'd0, 16'd99);
        mem[3] = mk(3, 16'd500, 16'd0, 16'd200);
        mem[4] = mk(4, 16'd1, 16'hFFCE, 16'd100);
        mem[5] = mk(5, 16'd10, 16'hFED4, 16'hFFFF);
        scan("edges", 6, 9'd100, 16'd500, 2, 0, 1'b0);
        rd("edges_e0", 0, mem[0]);
        rd("edges_e1", 1, mem[4]);

        // Column above 255 must stay positive after extension
        clear_mem();
        mem[0] = mk(0, 16'd5, 16'd200, 16'd400);
        mem[1] = mk(1, 16'd5, 16'hFFF6, 16'd299);
        scan("wide_x", 2, 9'd300, 16'd1000, 1, 0, 1'b0);
        rd("wide_x_e0", 0, mem[0]);

        // Ordering with duplicate depths
        clear_mem();
        mem[0] = mk(0, 16'd30, 16'hFFF6, 16'd10);
        mem[1] = mk(1, 16'd90, 16'hFFF6, 16'd10);
        mem[2] = mk(2, 16'd60, 16'hFFF6, 16'd10);
        mem[3] = mk(3, 16'd90, 16'hFFF6, 16'd10);
        scan("order", 4, 9'd0, 16'd1000, 4, 0, 1'b0);
`ifdef SPRITE_SORT_EN
        rd("order_e0", 0, mem[1]);
        rd("order_e1", 1, mem[3]);
        rd("order_e2", 2, mem[2]);
        rd("order_e3", 3, mem[0]);
`else
        for (int i = 0; i < 4; i++) rd("order_e", i, mem[i]);
`endif

        // More visible sprites than list slots
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = mk(i, 16'((i + 1) * 10), 16'hFFF6, 16'd10);
        scan("full", 10, 9'd0, 16'd1000, 8, 1, 1'b0);
`ifdef SPRITE_SORT_EN
        for (int i = 0; i < MV; i++) rd("full_e", i, mem[7 - i]);
`else
        for (int i = 0; i < MV; i++) rd("full_e", i, mem[i]);
`endif

        // Empty table: also clears the sticky overflow from the previous scan
        scan("empty", 0, 9'd0, 16'd1000, 0, 0, 1'b0);

        // Full table, start held through the whole scan, last entry tested in drain
        clear_mem();
        mem[0]   = mk(0, 16'd5, 16'd0, 16'd10);
        mem[127] = mk(127, 16'd7, 16'd0, 16'd10);
        scan("max", 128, 9'd3, 16'd100, 2, 0, 1'b1);
        repeat (8) @(negedge clk);
        check("max_single_scan_busy", MW'(busy), MW'(0));
`ifdef SPRITE_SORT_EN
        rd("max_e0", 0, mem[127]);
        rd("max_e1", 1, mem[0]);
`else
        rd("max_e0", 0, mem[0]);
        rd("max_e1", 1, mem[127]);
`endif

        // Reset at cycle 5 of a 128-entry scan: no done may follow
        @(negedge clk);
        active_count = 8'd128;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", MW'(busy), MW'(0));
        check("abort_count", MW'(sprite_count), MW'(0));
        check("abort_done", MW'(done), MW'(0));

        // Start coincident with reset is ignored
        rst = 1'b1;
        start = 1'b1;
        active_count = 8'd5;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_busy", MW'(busy), MW'(0));
        repeat (140) @(negedge clk);
        check("abort_no_done", MW'(dq.size() + rq.size()), MW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
